// File: rtl/alu1_responder.sv
// ALU1 command-execution responder: one operation in flight, single-cycle ALU ops,
// iterative shift-add MUL, result returned over a backpressured response handshake.
//
// state  | meaning
// IDLE   | ready for a request; captures operands on req_valid
// MUL    | shift-add multiply, one operand-B bit per cycle, fixed WIDTH cycles
// RESP   | result presented, held until rsp_ready
module alu1_responder #(
    parameter int WIDTH       = 64,
    parameter int CMD_WIDTH   = 4,
    parameter int NR_COMMANDS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CMD_WIDTH-1:0] req_cmd,
    input  logic [WIDTH-1:0]     req_in1,
    input  logic [WIDTH-1:0]     req_in2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_err,
    output logic [31:0]          op_count
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [CMD_WIDTH-1:0] CMD_NOP = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_ADD = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_SUB = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] CMD_AND = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] CMD_OR  = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] CMD_XOR = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] CMD_SHL = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] CMD_SHR = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] CMD_MUL = CMD_WIDTH'(8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   mul_cnt;
    logic             mul_last;
    logic             cmd_illegal;

    assign mul_last    = (mul_cnt == SHW'(WIDTH - 1));
    assign acc_sum     = mul_b[0] ? (mul_acc + mul_a) : mul_acc;
    assign cmd_illegal = (32'(req_cmd) >= 32'(NR_COMMANDS));

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_comb begin
        alu_res = '0;
        case (req_cmd)
            CMD_NOP: alu_res = '0;
            CMD_ADD: alu_res = req_in1 + req_in2;
            CMD_SUB: alu_res = req_in1 - req_in2;
            CMD_AND: alu_res = req_in1 & req_in2;
            CMD_OR:  alu_res = req_in1 | req_in2;
            CMD_XOR: alu_res = req_in1 ^ req_in2;
            CMD_SHL: alu_res = req_in1 << req_in2[SHW-1:0];
            CMD_SHR: alu_res = req_in1 >> req_in2[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = (req_cmd == CMD_MUL) ? S_MUL : S_RESP;
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_acc    <= '0;
            mul_cnt    <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_cmd == CMD_MUL) begin
                            mul_a   <= req_in1;
                            mul_b   <= req_in2;
                            mul_acc <= '0;
                            mul_cnt <= '0;
                            rsp_err <= 1'b0;
                        end else begin
                            rsp_result <= alu_res;
                            rsp_err    <= cmd_illegal;
                        end
                    end
                end
                S_MUL: begin
                    // no early exit on B==0 so MUL latency stays fixed
                    mul_acc <= acc_sum;
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    mul_cnt <= mul_cnt + SHW'(1);
                    if (mul_last) begin
                        rsp_result <= acc_sum;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
